debug_loader: RTL and testbench
===============================

Name: debug_loader

Overview:
Debug-side controller that owns the instruction-fetch stage's control inputs (enable, instruction-memory write port). It takes single-byte commands and program data from the UART receiver, assembles 32-bit instruction words, and writes them sequentially into instruction memory. It then releases the pipeline in continuous-run or single-step mode until the pipeline reports HLT retired. It sits between the UART RX and the datapath.

Parameters:
PC_BITS, 32, width of instruction-memory address output (matches fetch PC width)
INSTRUCTION_BITS, 32, instruction word width; must be a multiple of BYTE_BITS
INST_ADDRS_BITS, 10, implemented instruction-memory depth = 2**INST_ADDRS_BITS words
BYTE_BITS, 8, UART byte width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
i_rx_data  input  BYTE_BITS  received UART byte
i_rx_valid  input  1  one-cycle strobe, i_rx_data valid
i_halted  input  1  level; pipeline has retired HLT (0xFFFFFFFF)
o_enable  output  1  pipeline/fetch enable
o_write_inst_mem  output  1  instruction-memory write strobe
o_inst_mem_addr  output  PC_BITS  write address, zero-extended from INST_ADDRS_BITS
o_inst_mem_data  output  INSTRUCTION_BITS  write data
o_loaded  output  1  one-cycle pulse: program load completed with HLT
o_error  output  1  sticky: memory overflow during load
o_state  output  3  current FSM state encoding, for debug readback

Behaviour:
- All outputs registered. Reset: state IDLE, o_enable=0, o_write_inst_mem=0, addr=0, data=0, byte count=0, o_loaded=0, o_error=0.
- Commands: 'L'=0x4C, 'R'=0x52, 'S'=0x53, 'N'=0x4E. Any other byte is ignored in the command states.
- IDLE: 'L' -> LOAD (addr:=0, byte count:=0, o_error:=0); 'R' -> RUN; 'S' -> STEP.
- LOAD: every i_rx_valid shifts a byte into the word, MSB first.
  - On the 4th byte accepted at edge k: o_write_inst_mem=1 for exactly the cycle after edge k, with that word and the current addr. Addr increments at the same edge as the strobe drops.
  - A byte arriving during the strobe cycle is accepted into the next word; no byte is lost at full UART-strobe rate (back-to-back valid).
  - Command bytes are data in LOAD and are not decoded.
  - Word == 0xFFFFFFFF: the word is written, o_loaded pulses in the same cycle as its write strobe, then -> IDLE.
  - Overflow: if a non-HLT word is written at addr 2**INST_ADDRS_BITS-1, set o_error and -> IDLE. No wrap, no further writes.
- RUN: o_enable=1 every cycle from the cycle after entry. When i_halted=1 is sampled, o_enable drops the next cycle and the FSM goes to DONE. Bytes are ignored except 'S', which switches to STEP.
- STEP: o_enable=0 except a one-cycle pulse on the cycle after each 'N'. 'R' -> RUN. i_halted=1 -> DONE.
- DONE: o_enable=0. 'L' -> LOAD. All other bytes ignored.
- Invariant: o_enable and o_write_inst_mem are never high in the same cycle.
- Simultaneous i_halted and 'N' in STEP: halt wins, no enable pulse.
- Reset mid-load: partial word discarded; words already written remain in memory.
- State encodings: IDLE=0, LOAD=1, RUN=2, STEP=3, DONE=4.

Decomposition:
- Shared constants header (the existing constants file): command byte codes, HLT word, state encodings.
- One natural sub-module, word_assembler: byte shift register plus byte counter that emits a word_valid pulse. The FSM, address counter and enable logic stay in debug_loader.

Test Plan:
- Load: send 'L', then bytes 00 00 00 01, 12 34 56 78, FF FF FF FF -> strobes at addr 0/1/2 with data 0x00000001, 0x12345678, 0xFFFFFFFF; o_loaded pulses together with the third strobe; state returns to 0.
- Back-to-back rx_valid every cycle for the 8 bytes after 'L' -> exactly 2 write strobes with correct words; o_enable stays 0 throughout.
- Run: 'R', then assert i_halted 20 cycles later -> o_enable high for exactly 20 cycles, then 0; state=4; a subsequent 'N' has no effect.
- Step: 'S', 'N', 'X', 'N' -> exactly two one-cycle o_enable pulses, each one cycle after its 'N'; 'N' coinciding with i_halted -> no pulse, state=4.
- Overflow with INST_ADDRS_BITS=2: load 4 non-HLT words -> last strobe at addr 3, then o_error=1, state=0; next 'L' clears o_error.
- Async reset asserted after 2 bytes of a word -> all outputs reset immediately; a new 'L' plus a 4-byte word writes to addr 0 with only the new bytes.

Source files
------------

// File: rtl/debug_loader_pkg.sv
// debug_loader_pkg
//   Shared constants for the debug loader: UART command byte codes and the
//   FSM state encoding that is exposed on o_state for debug readback.
//   The HLT word is "all ones" at whatever INSTRUCTION_BITS is in use, so it
//   is expressed as a replication at the point of use rather than here.
package debug_loader_pkg;

   localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
   localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
   localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
   localparam logic [7:0] CMD_NEXT = 8'h4E;  // 'N'

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_RUN  = 3'd2,
      ST_STEP = 3'd3,
      ST_DONE = 3'd4
   } state_e;

endpackage

// File: rtl/debug_loader_word_assembler.sv
// debug_loader_word_assembler
//   Packs bytes MSB-first into instruction words.
//   word_o / word_valid_o are combinational: word_valid_o is high in the cycle
//   the last byte of a word is presented, and word_o is the complete word
//   including that byte, so the parent can register the write in the same
//   edge that accepts the byte.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   clear_i           discard any partial word (start of a new load)
//   byte_i            incoming byte
//   byte_valid_i      byte_i is to be accepted this cycle
//   word_o            assembled word (valid when word_valid_o)
//   word_valid_o      last byte of a word is being accepted this cycle
module debug_loader_word_assembler #(
   parameter int WORD_BITS = 32,
   parameter int BYTE_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear_i,
   input  logic [BYTE_BITS-1:0] byte_i,
   input  logic                 byte_valid_i,
   output logic [WORD_BITS-1:0] word_o,
   output logic                 word_valid_o
);

   localparam int N_BYTES = WORD_BITS / BYTE_BITS;
   localparam int CNT_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BYTES - 1);

   // Only the older bytes need storage; the newest byte comes straight from byte_i.
   logic [WORD_BITS-BYTE_BITS-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;

   assign word_o       = {shift_q, byte_i};
   assign word_valid_o = byte_valid_i && (cnt_q == CNT_LAST);

   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (byte_valid_i) begin
         shift_d = word_o[WORD_BITS-BYTE_BITS-1:0];
         cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/debug_loader.sv
// debug_loader
//   Debug-side controller for the fetch stage. Decodes single-byte UART
//   commands, loads program words sequentially into instruction memory, and
//   releases the pipeline in run or single-step mode until HLT retires.
//   All outputs are registered.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   i_rx_data/valid     received UART byte and its one-cycle strobe
//   i_halted            pipeline has retired HLT (level)
//   o_enable            pipeline/fetch enable
//   o_write_inst_mem    one-cycle instruction-memory write strobe
//   o_inst_mem_addr     write address (zero-extended)
//   o_inst_mem_data     write data
//   o_loaded            one-cycle pulse with the write strobe of the HLT word
//   o_error             sticky load overflow flag, cleared by the next 'L'
//   o_state             current FSM state (IDLE=0 LOAD=1 RUN=2 STEP=3 DONE=4)
module debug_loader
   import debug_loader_pkg::*;
#(
   parameter int PC_BITS          = 32,
   parameter int INSTRUCTION_BITS = 32,
   parameter int INST_ADDRS_BITS  = 10,
   parameter int BYTE_BITS        = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [BYTE_BITS-1:0]        i_rx_data,
   input  logic                        i_rx_valid,
   input  logic                        i_halted,
   output logic                        o_enable,
   output logic                        o_write_inst_mem,
   output logic [PC_BITS-1:0]          o_inst_mem_addr,
   output logic [INSTRUCTION_BITS-1:0] o_inst_mem_data,
   output logic                        o_loaded,
   output logic                        o_error,
   output logic [2:0]                  o_state
);

   localparam logic [INST_ADDRS_BITS-1:0]  ADDR_LAST = '1;
   localparam logic [INSTRUCTION_BITS-1:0] HLT_WORD  = '1;

   state_e                        state_q, state_d;
   logic                          enable_q, enable_d;
   logic                          write_q, write_d;
   logic [INST_ADDRS_BITS-1:0]    addr_q, addr_d;
   logic [INSTRUCTION_BITS-1:0]   data_q, data_d;
   logic                          loaded_q, loaded_d;
   logic                          error_q, error_d;

   logic                          asm_clear;
   logic                          asm_valid;
   logic [INSTRUCTION_BITS-1:0]   asm_word;
   logic                          asm_word_valid;

   logic rx_load, rx_run, rx_step, rx_next;

   assign rx_load = i_rx_valid && (i_rx_data == BYTE_BITS'(CMD_LOAD));
   assign rx_run  = i_rx_valid && (i_rx_data == BYTE_BITS'(CMD_RUN));
   assign rx_step = i_rx_valid && (i_rx_data == BYTE_BITS'(CMD_STEP));
   assign rx_next = i_rx_valid && (i_rx_data == BYTE_BITS'(CMD_NEXT));

   // In LOAD every byte is program data, including command codes.
   assign asm_valid = i_rx_valid && (state_q == ST_LOAD);

   debug_loader_word_assembler #(
      .WORD_BITS (INSTRUCTION_BITS),
      .BYTE_BITS (BYTE_BITS)
   ) u_word_assembler (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (asm_clear),
      .byte_i       (i_rx_data),
      .byte_valid_i (asm_valid),
      .word_o       (asm_word),
      .word_valid_o (asm_word_valid)
   );

   always_comb begin
      state_d   = state_q;
      enable_d  = 1'b0;
      write_d   = 1'b0;
      loaded_d  = 1'b0;
      error_d   = error_q;
      data_d    = data_q;
      addr_d    = addr_q;
      asm_clear = 1'b0;

      // The address advances on the edge where the strobe drops. It holds at
      // the last location rather than wrapping; overflow ends the load anyway.
      if (write_q && (addr_q != ADDR_LAST)) begin
         addr_d = addr_q + 1'b1;
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (rx_load) begin
               state_d   = ST_LOAD;
               addr_d    = '0;
               error_d   = 1'b0;
               asm_clear = 1'b1;
            end else if (state_q == ST_IDLE && rx_run) begin
               state_d = ST_RUN;
            end else if (state_q == ST_IDLE && rx_step) begin
               state_d = ST_STEP;
            end
         end

         ST_LOAD: begin
            if (asm_word_valid) begin
               write_d = 1'b1;
               data_d  = asm_word;
               if (asm_word == HLT_WORD) begin
                  loaded_d = 1'b1;
                  state_d  = ST_IDLE;
               end else if (addr_q == ADDR_LAST) begin
                  error_d = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end

         ST_RUN: begin
            if (i_halted) begin
               state_d = ST_DONE;
            end else if (rx_step) begin
               state_d = ST_STEP;
            end else begin
               enable_d = 1'b1;
            end
         end

         ST_STEP: begin
            // Halt takes priority over a coincident 'N'.
            if (i_halted) begin
               state_d = ST_DONE;
            end else if (rx_run) begin
               state_d = ST_RUN;
            end else if (rx_next) begin
               enable_d = 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         enable_q <= 1'b0;
         write_q  <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         loaded_q <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         enable_q <= enable_d;
         write_q  <= write_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         loaded_q <= loaded_d;
         error_q  <= error_d;
      end
   end

   assign o_enable         = enable_q;
   assign o_write_inst_mem = write_q;
   assign o_inst_mem_addr  = PC_BITS'(addr_q);
   assign o_inst_mem_data  = data_q;
   assign o_loaded         = loaded_q;
   assign o_error          = error_q;
   assign o_state          = state_q;

endmodule

// File: tb/tb_debug_loader.sv
// Testbench for debug_loader, built with a 4-word instruction memory so the
// overflow boundary is reachable quickly.
module tb_debug_loader;

   localparam int AB    = 2;
   localparam int DEPTH = 1 << AB;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  i_rx_data;
   logic        i_rx_valid;
   logic        i_halted;
   logic        o_enable;
   logic        o_write_inst_mem;
   logic [31:0] o_inst_mem_addr;
   logic [31:0] o_inst_mem_data;
   logic        o_loaded;
   logic        o_error;
   logic [2:0]  o_state;

   always #5 clk = ~clk;

   debug_loader #(
      .PC_BITS          (32),
      .INSTRUCTION_BITS (32),
      .INST_ADDRS_BITS  (AB),
      .BYTE_BITS        (8)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .i_rx_data        (i_rx_data),
      .i_rx_valid       (i_rx_valid),
      .i_halted         (i_halted),
      .o_enable         (o_enable),
      .o_write_inst_mem (o_write_inst_mem),
      .o_inst_mem_addr  (o_inst_mem_addr),
      .o_inst_mem_data  (o_inst_mem_data),
      .o_loaded         (o_loaded),
      .o_error          (o_error),
      .o_state          (o_state)
   );

   // ---------------- scoreboard ----------------
   int          vectors     = 0;
   int          miscompares = 0;
   int          en_cnt      = 0;
   logic [64:0] got_q[$];   // {loaded, addr, data} observed per strobe
   logic [64:0] exp_q[$];
   logic [31:0] words_q[$];

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       h;
      logic       exp_en;
      logic [2:0] exp_st;
   } vec_t;
   vec_t tbl[10];

   task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Mid-cycle monitor: records strobes and loaded pulses, counts enable cycles.
   always @(negedge clk) begin
      if (rst) begin
         if (o_write_inst_mem || o_loaded)
            got_q.push_back({o_loaded, o_inst_mem_addr, o_inst_mem_data});
         if (o_enable) en_cnt++;
         if (o_enable && o_write_inst_mem) begin
            vectors++;
            miscompares++;
            $display("FAIL invariant: enable=%0b write=%0b both high", o_enable, o_write_inst_mem);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      cyc();
      i_rx_valid = 1'b0;
      i_rx_data  = 8'($urandom_range(0, 255));
      repeat (gap) cyc();
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom;
      if (w == 32'hFFFF_FFFF) w = 32'h0;
      return w;
   endfunction

   // Reference: word i of the list lands at base+i; the list ends at the
   // first HLT word or at the last memory location (overflow -> error).
   task automatic run_load(input string name, input bit send_l, input int base, input int gap_max);
      bit          term;
      bit          err;
      bit          hlt;
      int          e0;
      logic [31:0] w;
      term = 1'b0;
      err  = 1'b0;
      e0   = en_cnt;
      exp_q.delete();
      for (int i = 0; i < words_q.size(); i++) begin
         hlt = (words_q[i] == 32'hFFFF_FFFF);
         exp_q.push_back({hlt, 32'(base + i), words_q[i]});
         if (hlt) begin term = 1'b1; break; end
         if (base + i == DEPTH - 1) begin term = 1'b1; err = 1'b1; break; end
      end
      if (send_l) send_byte(8'h4C, $urandom_range(0, gap_max));
      for (int i = 0; i < exp_q.size(); i++) begin
         w = words_q[i];
         for (int b = 0; b < 4; b++)
            send_byte(w[31-8*b -: 8], $urandom_range(0, gap_max));
      end
      repeat (3) cyc();
      check({name, "_count"}, 65'(got_q.size()), 65'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check({name, "_write"}, got_q[i], exp_q[i]);
      check({name, "_error"}, 65'(o_error), 65'(err));
      check({name, "_state"}, 65'(o_state), term ? 65'd0 : 65'd1);
      check({name, "_no_enable"}, 65'(en_cnt - e0), 65'd0);
      got_q.delete();
   endtask

   // ---------------- test ----------------
   initial begin
      int          n;
      int          e0;
      logic [7:0]  junk;

      rst        = 1'b1;
      i_rx_valid = 1'b0;
      i_rx_data  = 8'h00;
      i_halted   = 1'b0;
      #1 rst = 1'b0;
      repeat (2) cyc();
      check("rst_state",  65'(o_state), 65'd0);
      check("rst_enable", 65'(o_enable), 65'd0);
      check("rst_write",  65'(o_write_inst_mem), 65'd0);
      check("rst_addr",   65'(o_inst_mem_addr), 65'd0);
      check("rst_data",   65'(o_inst_mem_data), 65'd0);
      check("rst_loaded", 65'(o_loaded), 65'd0);
      check("rst_error",  65'(o_error), 65'd0);
      rst = 1'b1;
      cyc();

      // Basic load terminated by HLT.
      words_q = '{32'h0000_0001, 32'h1234_5678, 32'hFFFF_FFFF};
      run_load("load_basic", 1'b1, 0, 2);

      // Back-to-back bytes, two words, no HLT: stays in LOAD.
      words_q = '{rand_word(), rand_word()};
      run_load("b2b", 1'b1, 0, 0);

      // Two more words fill addresses 2 and 3 -> overflow.
      words_q = '{rand_word(), rand_word()};
      run_load("overflow", 1'b0, 2, 1);

      // A new 'L' clears the sticky error.
      send_byte(8'h4C, 0);
      check("err_clear", 65'(o_error), 65'd0);
      check("err_clear_state", 65'(o_state), 65'd1);
      words_q = '{32'hFFFF_FFFF};
      run_load("hlt_only", 1'b0, 0, 1);

      // Randomized loads: 0..3 words plus HLT, or 4 words without HLT (overflow).
      for (int it = 0; it < 10; it++) begin
         junk = 8'($urandom_range(0, 255));
         if (junk == 8'h4C || junk == 8'h52 || junk == 8'h53) junk = 8'h00;
         send_byte(junk, $urandom_range(0, 2));
         n = $urandom_range(0, 4);
         words_q.delete();
         for (int k = 0; k < n; k++) words_q.push_back(rand_word());
         if (n < 4) words_q.push_back(32'hFFFF_FFFF);
         run_load("rand_load", 1'b1, 0, 2);
      end

      // Run until halted 20 cycles after the 'R'.
      e0 = en_cnt;
      send_byte(8'h52, 0);
      repeat (20) cyc();
      i_halted = 1'b1;
      cyc();
      cyc();
      check("run_enable_cycles", 65'(en_cnt - e0), 65'd20);
      check("run_done_state", 65'(o_state), 65'd4);
      i_halted = 1'b0;
      send_byte(8'h4E, 2);
      check("done_n_ignored", 65'(en_cnt - e0), 65'd20);
      check("done_state", 65'(o_state), 65'd4);

      // Step mode, cycle by cycle.
      rst = 1'b0;
      cyc();
      rst = 1'b1;
      cyc();
      tbl[0] = '{1'b1, 8'h53, 1'b0, 1'b0, 3'd3};
      tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd3};
      tbl[2] = '{1'b1, 8'h4E, 1'b0, 1'b1, 3'd3};
      tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd3};
      tbl[4] = '{1'b1, 8'h58, 1'b0, 1'b0, 3'd3};
      tbl[5] = '{1'b1, 8'h4E, 1'b0, 1'b1, 3'd3};
      tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd3};
      tbl[7] = '{1'b1, 8'h4E, 1'b1, 1'b0, 3'd4};
      tbl[8] = '{1'b1, 8'h4E, 1'b0, 1'b0, 3'd4};
      tbl[9] = '{1'b1, 8'h52, 1'b0, 1'b0, 3'd4};
      for (int i = 0; i < 10; i++) begin
         i_rx_valid = tbl[i].v;
         i_rx_data  = tbl[i].d;
         i_halted   = tbl[i].h;
         cyc();
         check($sformatf("step_en_%0d", i), 65'(o_enable), 65'(tbl[i].exp_en));
         check($sformatf("step_state_%0d", i), 65'(o_state), 65'(tbl[i].exp_st));
      end
      i_rx_valid = 1'b0;
      i_halted   = 1'b0;

      // Reset in the middle of a word.
      words_q = '{32'hA5A5_0001};
      run_load("pre_reset", 1'b1, 0, 1);
      send_byte(8'hDE, 0);
      send_byte(8'hAD, 0);
      #2 rst = 1'b0;
      #1;
      check("midrst_state",  65'(o_state), 65'd0);
      check("midrst_addr",   65'(o_inst_mem_addr), 65'd0);
      check("midrst_data",   65'(o_inst_mem_data), 65'd0);
      check("midrst_write",  65'(o_write_inst_mem), 65'd0);
      check("midrst_enable", 65'(o_enable), 65'd0);
      rst = 1'b1;
      cyc();
      words_q = '{32'h0BAD_F00D};
      run_load("post_reset", 1'b1, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
